// File: rtl/comparador_serie.sv
`default_nettype none
// ============================================================================
//  Module   : comparador_serie
//  Purpose  : Digit-serial magnitude comparator. Compares two K-bit operands
//             D bits per clock over N = ceil(K/D) cycles and reports
//             greater / equal / less. The scan order is chosen per operation:
//             dir=0 walks digits LSB first, dir=1 walks them MSB first.
//             Both orders take exactly N cycles and give the same result.
//
//  Parameters:
//     K        operand width in bits (K >= 1)
//     D        digit width, bits compared per cycle (1 <= D <= K)
//
//  Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous, active-low reset
//     start    in   latch A, B, dir and begin a comparison
//     dir      in   0 = right-to-left (LSB first), 1 = left-to-right
//     A, B     in   K-bit operands
//     busy     out  comparison in progress
//     valid    out  one-cycle pulse, results have just been updated
//     mayor    out  A >  B
//     igual    out  A == B
//     menor    out  A <  B
//
//  Build option:
//     COMPARADOR_SIGNED_EN  when defined, A and B are two's complement.
//
//  Revision : 1.0 - initial release
// ============================================================================
module comparador_serie #(
   parameter int K = 8,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         dir,
   input  logic [K-1:0] A,
   input  logic [K-1:0] B,
   output logic         busy,
   output logic         valid,
   output logic         mayor,
   output logic         igual,
   output logic         menor
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int c_n  = (K + D - 1) / D;                 // processing steps
   localparam int c_w  = c_n * D;                         // padded width
   localparam int c_cw = (c_n > 1) ? $clog2(c_n) : 1;     // counter width
   localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

   // ------------------------------------------------------------------------
   // State machine encoding
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      s_idle    = 2'd0,
      s_compara = 2'd1,
      s_listo   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // ------------------------------------------------------------------------
   // Operand mapping. In signed mode flipping the sign bit turns two's
   // complement order into plain unsigned order; the zero padding above
   // bit K-1 is added afterwards so it is never touched by the flip.
   // ------------------------------------------------------------------------
   logic [K-1:0]   w_a_map;
   logic [K-1:0]   w_b_map;
   logic [c_w-1:0] w_a_ext;
   logic [c_w-1:0] w_b_ext;

`ifdef COMPARADOR_SIGNED_EN
   always_comb begin
      w_a_map        = A;
      w_b_map        = B;
      w_a_map[K-1]   = ~A[K-1];
      w_b_map[K-1]   = ~B[K-1];
   end
`else
   assign w_a_map = A;
   assign w_b_map = B;
`endif

   always_comb begin
      w_a_ext          = '0;
      w_b_ext          = '0;
      w_a_ext[K-1:0]   = w_a_map;
      w_b_ext[K-1:0]   = w_b_map;
   end

   // ------------------------------------------------------------------------
   // Registered datapath. Operands are held as arrays of digits so that
   // digit j is simply element j (bits [j*D +: D] of the padded operand).
   // ------------------------------------------------------------------------
   logic [c_n-1:0][D-1:0] r_a;
   logic [c_n-1:0][D-1:0] r_b;
   logic                  r_dir;
   logic [c_cw-1:0]       r_cnt;
   logic                  r_eq;
   logic                  r_gt;
   logic                  r_lt;
   logic                  r_valid;
   logic                  r_mayor;
   logic                  r_igual;
   logic                  r_menor;

   // FSM control strobes
   logic w_load;
   logic w_step;
   logic w_done;

   // ------------------------------------------------------------------------
   // Digit selection and accumulator update
   // ------------------------------------------------------------------------
   logic [c_cw-1:0] w_idx;
   logic [D-1:0]    w_da;
   logic [D-1:0]    w_db;
   logic            w_upd;
   logic            w_eq_n;
   logic            w_gt_n;
   logic            w_lt_n;

   // MSB-first mode walks the digits downward from N-1.
   assign w_idx = r_dir ? (c_last - r_cnt) : r_cnt;
   assign w_da  = r_a[w_idx];
   assign w_db  = r_b[w_idx];

   // LSB first: every differing digit overrides, so the most significant
   // difference is the one left standing at the end.
   // MSB first: only the first differing digit counts; once eq drops the
   // verdict is frozen.
   assign w_upd  = (w_da != w_db) && (!r_dir || r_eq);
   assign w_gt_n = w_upd ? (w_da > w_db) : r_gt;
   assign w_lt_n = w_upd ? (w_da < w_db) : r_lt;
   assign w_eq_n = w_upd ? 1'b0          : r_eq;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= s_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and control strobes
   // LISTO accepts a new start exactly like IDLE, which gives back-to-back
   // operation at one comparison every N+1 cycles.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         s_idle, s_listo: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = s_compara;
            end else begin
               w_state_next = s_idle;
            end
         end
         s_compara: begin
            // start is deliberately not looked at here
            w_step = 1'b1;
            if (r_cnt == c_last) begin
               w_done       = 1'b1;
               w_state_next = s_listo;
            end
         end
         default: begin
            w_state_next = s_idle;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and result registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_dir   <= 1'b0;
         r_cnt   <= '0;
         r_eq    <= 1'b0;
         r_gt    <= 1'b0;
         r_lt    <= 1'b0;
         r_valid <= 1'b0;
         r_mayor <= 1'b0;
         r_igual <= 1'b0;
         r_menor <= 1'b0;
      end else begin
         if (w_load) begin
            r_a   <= w_a_ext;
            r_b   <= w_b_ext;
            r_dir <= dir;
            r_cnt <= '0;
            r_eq  <= 1'b1;
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
         end else if (w_step) begin
            r_cnt <= w_done ? '0 : (r_cnt + c_cw'(1));
            r_eq  <= w_eq_n;
            r_gt  <= w_gt_n;
            r_lt  <= w_lt_n;
         end

         r_valid <= w_done;

         // Results only move on completion, so they are stable while busy.
         if (w_done) begin
            r_mayor <= w_gt_n;
            r_igual <= w_eq_n;
            r_menor <= w_lt_n;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy  = (r_state == s_compara);
   assign valid = r_valid;
   assign mayor = r_mayor;
   assign igual = r_igual;
   assign menor = r_menor;

endmodule
`default_nettype wire
